// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side streaming block: default data
// width, delivery counter width and the skid-buffer occupancy states.
package fifo_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned OCC_W      = 2;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } skid_state_e;

    // Number of buffered entries represented by a skid state.
    function automatic logic [OCC_W-1:0] occ_of(input skid_state_e s);
        logic [OCC_W-1:0] n;
        case (s)
            S_ONE:   n = OCC_W'(1);
            S_TWO:   n = OCC_W'(2);
            default: n = OCC_W'(0);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/fifo_rd_if.sv
// Read side of the team's synchronous FIFO.
// Ports: clk, rst (shared with the FIFO).
// reader modport: clk, rst, fifo_empty, fifo_data_out in; fifo_r_en out.
interface fifo_rd_if #(
    parameter int unsigned DATA_W = fifo_pkg::DATA_W_DEF
) (
    input logic clk,
    input logic rst
);

    logic              fifo_empty;
    logic              fifo_r_en;
    logic [DATA_W-1:0] fifo_data_out;

    modport reader (
        input  clk,
        input  rst,
        input  fifo_empty,
        input  fifo_data_out,
        output fifo_r_en
    );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer with occupancy FSM.
// Ports: clk, rst (sync, active-high); push/din load a new entry at the tail;
// pop retires the head; data/valid present the head (registered);
// occ_c reports the current occupancy decoded from the state.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic [OCC_W-1:0]  occ_c
);

    skid_state_e       state, state_nxt;
    logic [DATA_W-1:0] tail;
    logic [DATA_W-1:0] head_nxt, tail_nxt;

    assign occ_c = occ_of(state);

    // Next state and storage moves; a push behind a pop lands after the
    // surviving entry so delivery order is preserved.
    always_comb begin
        state_nxt = state;
        head_nxt  = data;
        tail_nxt  = tail;
        case (state)
            S_EMPTY: begin
                if (push) begin
                    head_nxt  = din;
                    state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    head_nxt = din;
                end else if (push) begin
                    tail_nxt  = din;
                    state_nxt = S_TWO;
                end else if (pop) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    head_nxt = tail;
                    if (push) begin
                        tail_nxt = din;
                    end else begin
                        state_nxt = S_ONE;
                    end
                end
            end
            default: begin
                state_nxt = S_EMPTY;
            end
        endcase
    end

    // State and storage registers; valid tracks the next state so it is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
            data  <= '0;
            tail  <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_nxt;
            data  <= head_nxt;
            tail  <= tail_nxt;
            valid <= (state_nxt != S_EMPTY);
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts the read side of a 1-cycle-latency sync FIFO into a valid/ready
// stream at up to one byte per cycle, without a combinational path from FIFO
// data to the stream.
// Ports: clk, rst (sync, active-high); en gates new FIFO reads only;
// fifo_empty/fifo_r_en/fifo_data_out to the FIFO; m_data/m_valid/m_ready to
// the consumer; pop_count counts delivered bytes (wrapping).
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    output logic              fifo_r_en,
    input  logic [DATA_W-1:0] fifo_data_out,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  pop_count
);

    fifo_rd_if #(.DATA_W(DATA_W)) rd_if (.clk(clk), .rst(rst));

    assign rd_if.fifo_empty    = fifo_empty;
    assign rd_if.fifo_data_out = fifo_data_out;
    assign fifo_r_en           = rd_if.fifo_r_en;

    logic             infl;
    logic             pop;
    logic [OCC_W-1:0] occ;
    logic [2:0]       load;

    assign pop = m_valid && m_ready;

    // Issue a read only if the entry it returns is guaranteed a slot:
    // occ + infl - pop <= 1, rearranged to stay unsigned.
    always_comb begin
        load            = 3'(occ) + 3'(infl);
        rd_if.fifo_r_en = 1'b0;
        if (!rd_if.rst && en && !rd_if.fifo_empty && (load <= 3'(1) + 3'(pop))) begin
            rd_if.fifo_r_en = 1'b1;
        end
    end

    // In-flight flag and delivery counter; clearing infl on reset drops the
    // byte returning from a read issued just before reset.
    always_ff @(posedge rd_if.clk) begin
        if (rd_if.rst) begin
            infl      <= 1'b0;
            pop_count <= '0;
        end else begin
            infl <= rd_if.fifo_r_en;
            if (pop) begin
                pop_count <= pop_count + CNT_W'(1);
            end
        end
    end

    fifo_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (infl),
        .din   (rd_if.fifo_data_out),
        .pop   (pop),
        .data  (m_data),
        .valid (m_valid),
        .occ_c (occ)
    );

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width in bits of FIFO read data and stream data.
REQ-002 SHALL have port clk  input  1  single clock; all logic updates on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-004 SHALL have port en  input  1  read-issue enable; low blocks new FIFO reads only.
REQ-005 SHALL have port fifo_empty  input  1  FIFO empty flag from the sync FIFO read side.
REQ-006 SHALL have port fifo_r_en  output  1  FIFO pop request, one entry per cycle asserted.
REQ-007 SHALL have port fifo_data_out  input  DATA_W  FIFO read data, valid the cycle after fifo_r_en.
REQ-008 SHALL have port m_data  output  DATA_W  stream data to consumer.
REQ-009 SHALL have port m_valid  output  1  m_data holds a valid byte.
REQ-010 SHALL have port m_ready  input  1  consumer accepts m_data this cycle.
REQ-011 SHALL have port pop_count  output  16  number of bytes delivered (m_valid && m_ready) since reset.

Function
REQ-012 SHALL hold a 2-entry skid buffer; occupancy occ in {0,1,2}; state names S_EMPTY, S_ONE, S_TWO.
REQ-013 SHALL track one in-flight flag infl, set the cycle after fifo_r_en is asserted.
REQ-014 SHALL define pop = m_valid && m_ready.
REQ-015 SHALL assert fifo_r_en combinationally when en && !fifo_empty && (occ + infl - pop) <= 1.
REQ-016 SHALL capture fifo_data_out into the skid tail on the cycle infl is 1; read latency FIFO-to-buffer is 1 cycle.
REQ-017 SHALL drive m_valid = (occ != 0) and m_data = head entry; no combinational path from fifo_data_out to m_data.
REQ-018 SHALL keep m_data stable while m_valid && !m_ready.
REQ-019 SHALL, on simultaneous capture and pop, keep occ unchanged and preserve order (the new byte queues behind the remaining byte).
REQ-020 SHALL sustain 1 byte/cycle when fifo_empty=0, en=1, m_ready=1 continuously; first m_valid 2 cycles after first fifo_r_en.
REQ-021 SHALL never overflow the skid buffer: occ + infl <= 2 at all times.
REQ-022 SHALL deliver bytes already in flight or buffered when en deasserts; only new reads stop.
REQ-023 SHALL increment pop_count by 1 per pop, wrapping 16'hFFFF -> 16'h0000.
REQ-024 SHALL leave FSM transitions: S_EMPTY->S_ONE on capture; S_ONE->S_TWO on capture without pop; S_TWO->S_ONE on pop without capture; S_ONE->S_EMPTY on pop without capture; all other cases hold.

Reset
REQ-025 SHALL on rst: occ=0 (S_EMPTY), infl=0, m_valid=0, m_data=0, pop_count=0, fifo_r_en=0.
REQ-026 SHALL discard in-flight data returning the cycle after a reset; rst has priority over all other events.
REQ-027 SHALL force fifo_r_en=0 in any cycle rst=1.

Structure
REQ-028 SHALL place DATA_W default, the skid-state enum (S_EMPTY, S_ONE, S_TWO) and the counter width 16 in shared package fifo_pkg.
REQ-029 SHALL implement the 2-entry storage and occ FSM as sub-module fifo_skid_buf; top level holds issue logic, infl and pop_count.
REQ-030 SHALL connect to the FIFO read side through the team's FIFO interface using a reader modport with clk, rst, fifo_empty, fifo_data_out as inputs and fifo_r_en as output.

Verification
REQ-031 SHALL test: FIFO preloaded 8'hFA,8'hCC,8'h1C, en=1, m_ready=1 -> m_data FA,CC,1C on 3 consecutive cycles, pop_count=3.
REQ-032 SHALL test: 4 bytes queued, m_ready=0 -> exactly 2 fifo_r_en pulses, m_data=first byte held stable; m_ready=1 -> remaining bytes in order, no loss.
REQ-033 SHALL test: fifo_empty=1 throughout -> fifo_r_en never asserted, m_valid stays 0.
REQ-034 SHALL test: en dropped after 1 read issued -> that byte still delivered, no further fifo_r_en.
REQ-035 SHALL test: rst asserted with occ=2 and infl=1 -> next cycle m_valid=0, pop_count=0, returning byte discarded.
REQ-036 SHALL test: pop_count preset by 65535 pops, one more pop -> pop_count=0.
